// File: rtl/sc_popcount_acc.sv
// Stochastic-computing popcount accumulator: counts ones across a frame of
// bitstream words and emits saturating total and word count per frame.
module sc_popcount_acc #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_bs,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [LEN_WIDTH-1:0] out_len,
  output logic                 out_sat
);

  localparam int unsigned CNT_WIDTH = $clog2(IN_WIDTH + 1);
  localparam int unsigned SUM_WIDTH = ((ACC_WIDTH > CNT_WIDTH) ? ACC_WIDTH : CNT_WIDTH) + 1;
  localparam logic [SUM_WIDTH-1:0] ACC_MAX = SUM_WIDTH'({ACC_WIDTH{1'b1}});

  logic                 p1_valid;
  logic                 p1_last;
  logic [CNT_WIDTH-1:0] p1_cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0] len;
  logic                 sat;

  logic                 xfer;
  logic                 stall;
  logic                 consume;
  logic [CNT_WIDTH-1:0] in_cnt;
  logic [SUM_WIDTH-1:0] sum;
  logic                 acc_ovf;
  logic                 len_ovf;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [LEN_WIDTH-1:0] len_next;
  logic                 sat_next;

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;
  // Only a frame-closing word needs the output registers, so only it can stall.
  assign stall    = p1_valid && p1_last && out_valid && !out_ready;
  assign consume  = p1_valid && !stall;

  always_comb begin
    in_cnt = '0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      in_cnt = in_cnt + CNT_WIDTH'(in_bs[i]);
    end
  end

  // Saturating accumulate of the staged count and word length.
  always_comb begin
    sum      = SUM_WIDTH'(acc) + SUM_WIDTH'(p1_cnt);
    acc_ovf  = (sum > ACC_MAX);
    acc_next = acc_ovf ? {ACC_WIDTH{1'b1}} : ACC_WIDTH'(sum);
    len_ovf  = &len;
    len_next = len_ovf ? len : len + LEN_WIDTH'(1);
    sat_next = sat | acc_ovf | len_ovf;
  end

  // Stage 1: popcount register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid <= 1'b0;
      p1_last  <= 1'b0;
      p1_cnt   <= '0;
    end else if (!stall) begin
      p1_valid <= xfer;
      if (xfer) begin
        p1_cnt  <= in_cnt;
        p1_last <= in_last;
      end
    end
  end

  // Stage 2: frame accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      len       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_len   <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (consume) begin
        if (p1_last) begin
          out_valid <= 1'b1;
          out_data  <= acc_next;
          out_len   <= len_next;
          out_sat   <= sat_next;
          acc       <= '0;
          len       <= '0;
          sat       <= 1'b0;
        end else begin
          acc <= acc_next;
          len <= len_next;
          sat <= sat_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_sc_popcount_acc.sv
// Self-checking bench: two instances (wide and narrow accumulators) share one
// stimulus stream and are compared against a frame-level reference model.
module tb_sc_popcount_acc;

  localparam int unsigned IW   = 32;
  localparam int unsigned AW_A = 16;
  localparam int unsigned LW_A = 8;
  localparam int unsigned AW_B = 8;
  localparam int unsigned LW_B = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [IW-1:0]   in_bs;
  logic            in_last;
  logic            out_ready;

  logic            in_ready_a, out_valid_a, out_sat_a;
  logic [AW_A-1:0] out_data_a;
  logic [LW_A-1:0] out_len_a;
  logic            in_ready_b, out_valid_b, out_sat_b;
  logic [AW_B-1:0] out_data_b;
  logic [LW_B-1:0] out_len_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sc_popcount_acc #(.IN_WIDTH(IW), .ACC_WIDTH(AW_A), .LEN_WIDTH(LW_A)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_bs(in_bs), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_len(out_len_a),
    .out_sat(out_sat_a)
  );

  sc_popcount_acc #(.IN_WIDTH(IW), .ACC_WIDTH(AW_B), .LEN_WIDTH(LW_B)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_bs(in_bs), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_len(out_len_b),
    .out_sat(out_sat_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame result as {data, len, sat}, clamped to the instance's widths.
  function automatic logic [63:0] frame_result(input longint unsigned ones, input longint unsigned words,
                                               input int unsigned aw, input int unsigned lw);
    longint unsigned amax = (64'd1 << aw) - 1;
    longint unsigned lmax = (64'd1 << lw) - 1;
    longint unsigned d    = (ones > amax) ? amax : ones;
    longint unsigned l    = (words > lmax) ? lmax : words;
    logic            s    = (ones > amax) || (words > lmax);
    return (64'(d) << (lw + 1)) | (64'(l) << 1) | 64'(s);
  endfunction

  logic [63:0]     qa[$];
  logic [63:0]     qb[$];
  longint unsigned frame_ones  = 0;
  longint unsigned frame_words = 0;
  logic            prev_hold   = 1'b0;
  logic [63:0]     prev_a, prev_b, got;

  // Reference model and per-cycle compare, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      frame_ones  = 0;
      frame_words = 0;
      prev_hold   = 1'b0;
      check("rst_out_valid", 64'({out_valid_a, out_valid_b}), 64'd0);
      check("rst_in_ready", 64'({in_ready_a, in_ready_b}), 64'd3);
      check("rst_out_regs", 64'({out_data_a, out_len_a, out_sat_a}), 64'd0);
    end else begin
      check("in_ready_a", 64'(in_ready_a), 64'(!out_valid_a || out_ready));
      check("in_ready_b", 64'(in_ready_b), 64'(!out_valid_b || out_ready));
      if (prev_hold) begin
        check("hold_a", {63'(out_valid_a), 1'b0} | 64'({out_data_a, out_len_a, out_sat_a}),
              {63'(1), 1'b0} | prev_a);
        check("hold_b", {63'(out_valid_b), 1'b0} | 64'({out_data_b, out_len_b, out_sat_b}),
              {63'(1), 1'b0} | prev_b);
      end
      if (out_valid_a && out_ready) begin
        check("result_pending_a", 64'(qa.size() != 0), 64'd1);
        if (qa.size() != 0) check("result_a", 64'({out_data_a, out_len_a, out_sat_a}), qa.pop_front());
      end
      if (out_valid_b && out_ready) begin
        check("result_pending_b", 64'(qb.size() != 0), 64'd1);
        if (qb.size() != 0) check("result_b", 64'({out_data_b, out_len_b, out_sat_b}), qb.pop_front());
      end
      if (in_valid && in_ready_a) begin
        frame_ones  += 64'($countones(in_bs));
        frame_words += 1;
        if (in_last) begin
          qa.push_back(frame_result(frame_ones, frame_words, AW_A, LW_A));
          qb.push_back(frame_result(frame_ones, frame_words, AW_B, LW_B));
          frame_ones  = 0;
          frame_words = 0;
        end
      end
      prev_hold = out_valid_a && !out_ready;
      prev_a    = 64'({out_data_a, out_len_a, out_sat_a});
      prev_b    = 64'({out_data_b, out_len_b, out_sat_b});
    end
  end

  // Present one word and hold it until it is accepted (bounded).
  task automatic send(input logic [IW-1:0] bs, input logic last);
    int unsigned t = 0;
    in_valid = 1'b1;
    in_bs    = bs;
    in_last  = last;
    while (!in_ready_a && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) check("send_timeout", 64'(t), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_bs    = $urandom;
    in_last  = 1'($urandom);
  endtask

  task automatic expect_next(input string name, input int unsigned data, input int unsigned len,
                             input logic s);
    @(posedge clk); #1;
    check({name, "_valid"}, 64'(out_valid_a), 64'd1);
    check({name, "_data"}, 64'(out_data_a), 64'(data));
    check({name, "_len"}, 64'(out_len_a), 64'(len));
    check({name, "_sat"}, 64'(out_sat_a), 64'(s));
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bs = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Single all-ones word: result not yet visible one edge after capture.
    send(32'hFFFF_FFFF, 1'b1);
    check("lat_early_valid", 64'(out_valid_a), 64'd0);
    expect_next("single", 32, 1, 1'b0);
    idle(2);

    // Four-word frame including an all-zero word.
    send(32'h0000_000F, 1'b0);
    send(32'h0000_0000, 1'b0);
    send(32'hFFFF_0000, 1'b0);
    send(32'h0000_0001, 1'b1);
    expect_next("frame4", 21, 4, 1'b0);
    idle(2);

    // Narrow accumulator saturates on 9 all-ones words.
    for (int i = 0; i < 9; i++) send(32'hFFFF_FFFF, 1'(i == 8));
    expect_next("wide9", 288, 9, 1'b0);
    check("narrow9", 64'({out_valid_b, out_data_b, out_len_b, out_sat_b}),
          64'({1'b1, 8'd255, 4'd9, 1'b1}));
    idle(2);

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 3; i++) send(32'hFFFF_FFFF, 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    send(32'h0000_0003, 1'b1);
    expect_next("after_rst", 2, 1, 1'b0);
    idle(2);

    // Back-to-back single-word frames keep out_valid high for two cycles.
    send(32'h0000_00FF, 1'b1);
    send(32'h0000_0001, 1'b1);
    check("b2b_first", 64'({out_valid_a, out_data_a}), 64'({1'b1, 16'd8}));
    expect_next("b2b_second", 1, 1, 1'b0);
    @(posedge clk); #1;
    check("b2b_drop", 64'(out_valid_a), 64'd0);
    idle(2);

    // Backpressure: second frame's last stalls in stage 1 behind a held result.
    out_ready = 1'b0;
    in_valid = 1'b1; in_bs = 32'h0000_0007; in_last = 1'b1;
    @(posedge clk); #1;
    in_bs = 32'h0000_F0F0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_held", 64'({in_ready_a, out_valid_a, out_data_a}), 64'({1'b0, 1'b1, 16'd3}));
    idle(3);
    check("bp_still_held", 64'({in_ready_a, out_valid_a, out_data_a, out_len_a}),
          64'({1'b0, 1'b1, 16'd3, 8'd1}));
    out_ready = 1'b1;
    #1;
    check("bp_ready_back", 64'(in_ready_a), 64'd1);
    expect_next("bp_second", 8, 1, 1'b0);
    @(posedge clk); #1;
    check("bp_drain", 64'(out_valid_a), 64'd0);
    idle(2);

    // Randomized traffic with varying frame lengths and consumer backpressure.
    for (int i = 0; i < 3000; i++) begin
      int unsigned last_div;
      last_div = (i < 1000) ? 2 : ((i < 2000) ? 6 : 25);
      if (i == 1500) begin
        rst = 1'b1; in_valid = 1'b0;
        idle(2);
        rst = 1'b0;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       in_bs = '0;
        1:       in_bs = '1;
        default: in_bs = $urandom;
      endcase
      in_last   = ($urandom_range(0, last_div - 1) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end

    // Drain: close any open frame and collect all outstanding results.
    send(32'h0000_0000, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    idle(2);
    check("drain_empty", 64'(qa.size() + qb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
